lsu_ctrl: RTL

Load/store initiator that sits between the execute stage and the data memory `dm`. It accepts one load or store request at a time over a valid/ready handshake and drives `dm`'s write-enable, load-select, byte-offset, word-address and write-data inputs. Aligned accesses complete as a single `dm` access. Misaligned word and halfword accesses are split into sequential byte accesses, and the load result is assembled and extended locally.

---
 rtl/lsu_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store initiator between execute and dm; misaligned h/w accesses become byte-by-byte dm accesses.
// Latency: aligned accept->resp_valid 2 cycles, split N+1 cycles (N=2/4), rejected misaligned 1 cycle.
// Backpressure: req_ready only in IDLE (and not in reset); no response backpressure, resp_valid pulses once.
module lsu_ctrl #(
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dm_we,
    output logic [3:0]  dm_loadsel,
    output logic [1:0]  dm_byte,
    output logic [6:0]  dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);
    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t      state;
    logic [3:0]  op_r;
    logic        we_r;
    logic [8:0]  addr_r;
    logic [31:0] wdata_r;
    logic [1:0]  k_r;
    logic [1:0]  last_r;
    logic [31:0] rdata_r;
    logic        dm_we_r;

    logic [1:0]  req_size;
    logic        req_aligned;
    logic [3:0]  acc_loadsel;
    logic [31:0] acc_din;
    logic [1:0]  nxt_k;
    logic [8:0]  nxt_a;
    logic [7:0]  nxt_wbyte;
    logic [31:0] asm_rdata;
    logic [31:0] split_rdata;
    logic        unused_addr_hi;

    // Only a 512-byte window is addressed; upper address bits are ignored.
    assign unused_addr_hi = ^req_addr[31:9];

    // Ready only when idle; reset forces it low even while the state register still says IDLE.
    assign req_ready = (state == IDLE) && !rst;

    // Reset cancels a write that is in flight so an aborted store never commits under the reset edge.
    assign dm_we = dm_we_r && !rst;

    // Decode access size, alignment and the single-access dm controls for the incoming request.
    always_comb begin
        req_size = SZ_W;
        if (req_we) begin
            if (req_op == 4'b0101)      req_size = SZ_B;
            else if (req_op == 4'b0110) req_size = SZ_H;
        end else begin
            if (req_op == 4'b0001 || req_op == 4'b0010)      req_size = SZ_B;
            else if (req_op == 4'b0011 || req_op == 4'b0100) req_size = SZ_H;
        end

        req_aligned = 1'b0;
        case (req_size)
            SZ_B:    req_aligned = 1'b1;
            SZ_H:    req_aligned = ~req_addr[0];
            default: req_aligned = (req_addr[1:0] == 2'b00);
        endcase

        acc_loadsel = req_op;
        acc_din     = 32'h0;
        if (req_we) begin
            case (req_size)
                SZ_B: begin
                    acc_loadsel = 4'b0101;
                    acc_din     = {4{req_wdata[7:0]}};
                end
                SZ_H: begin
                    acc_loadsel = 4'b0110;
                    acc_din     = {2{req_wdata[15:0]}};
                end
                default: begin
                    acc_loadsel = 4'b0111;
                    acc_din     = req_wdata;
                end
            endcase
        end
    end

    // Next split byte address/data, and the load result with the current byte merged and extended.
    always_comb begin
        nxt_k     = k_r + 2'd1;
        nxt_a     = addr_r + {7'd0, nxt_k};
        nxt_wbyte = wdata_r[{nxt_k, 3'b000} +: 8];
        asm_rdata = rdata_r;
        asm_rdata[{k_r, 3'b000} +: 8] = dm_dout[7:0];
        if (op_r == 4'b0011)
            split_rdata = {{16{asm_rdata[15]}}, asm_rdata[15:0]};
        else if (op_r == 4'b0100)
            split_rdata = {16'h0, asm_rdata[15:0]};
        else
            split_rdata = asm_rdata;
    end

    // Control FSM with registered response and dm outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_r       <= 4'h0;
            we_r       <= 1'b0;
            addr_r     <= 9'h0;
            wdata_r    <= 32'h0;
            k_r        <= 2'd0;
            last_r     <= 2'd0;
            rdata_r    <= 32'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            dm_we_r    <= 1'b0;
            dm_loadsel <= 4'h0;
            dm_byte    <= 2'd0;
            dm_addr    <= 7'h0;
            dm_din     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    if (req_valid) begin
                        op_r    <= req_op;
                        we_r    <= req_we;
                        addr_r  <= req_addr[8:0];
                        wdata_r <= req_wdata;
                        rdata_r <= 32'h0;
                        k_r     <= 2'd0;
                        last_r  <= (req_size == SZ_H) ? 2'd1 : 2'd3;
                        if (req_aligned) begin
                            state      <= ACCESS;
                            dm_we_r    <= req_we;
                            dm_loadsel <= acc_loadsel;
                            dm_byte    <= req_addr[1:0];
                            dm_addr    <= req_addr[8:2];
                            dm_din     <= acc_din;
                        end else if (MISALIGN_SPLIT != 0) begin
                            state      <= SPLIT;
                            dm_we_r    <= req_we;
                            dm_loadsel <= req_we ? 4'b0101 : 4'b0010;
                            dm_byte    <= req_addr[1:0];
                            dm_addr    <= req_addr[8:2];
                            dm_din     <= req_we ? {4{req_wdata[7:0]}} : 32'h0;
                        end else begin
                            // Rejected: straight to the response, dm stays untouched.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    dm_we_r    <= 1'b0;
                    dm_loadsel <= 4'h0;
                    dm_byte    <= 2'd0;
                    dm_addr    <= 7'h0;
                    dm_din     <= 32'h0;
                    resp_valid <= 1'b1;
                    resp_rdata <= we_r ? 32'h0 : dm_dout;
                    state      <= RESP;
                end
                SPLIT: begin
                    if (k_r == last_r) begin
                        dm_we_r    <= 1'b0;
                        dm_loadsel <= 4'h0;
                        dm_byte    <= 2'd0;
                        dm_addr    <= 7'h0;
                        dm_din     <= 32'h0;
                        resp_valid <= 1'b1;
                        resp_rdata <= we_r ? 32'h0 : split_rdata;
                        state      <= RESP;
                    end else begin
                        k_r     <= nxt_k;
                        rdata_r <= asm_rdata;
                        dm_addr <= nxt_a[8:2];
                        dm_byte <= nxt_a[1:0];
                        dm_din  <= we_r ? {4{nxt_wbyte}} : 32'h0;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
